// File: rtl/clock_set_ctrl.sv
// Button-driven time-setting controller for the 24 h clock, running on the 1 kHz tick clock.
// Optional daylight-saving hour adjustment (spring_szn input) is built when CLOCK_SET_DST_EN is defined.
module clock_set_ctrl #(
  parameter int DEBOUNCE_MS = 20,
  parameter int TIMEOUT_MS  = 10000,
  parameter int BLINK_MS    = 250
) (
  input  logic        kh_clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
`ifdef CLOCK_SET_DST_EN
  input  logic        spring_szn,
`endif
  input  logic [26:0] cur_time,
  output logic        load_en,
  output logic [26:0] load_time,
  output logic        set_active,
  output logic [1:0]  field_sel,
  output logic        blink
);
  // state      | meaning
  // S_RUN      | clock free-running, waiting for mode press
  // S_EDIT_HR  | editing hours
  // S_EDIT_MIN | editing minutes
  // S_EDIT_SEC | editing seconds
  // S_COMMIT   | one-cycle parallel load of the edited time
  localparam logic [2:0] S_RUN      = 3'd0;
  localparam logic [2:0] S_EDIT_HR  = 3'd1;
  localparam logic [2:0] S_EDIT_MIN = 3'd2;
  localparam logic [2:0] S_EDIT_SEC = 3'd3;
  localparam logic [2:0] S_COMMIT   = 3'd4;

  localparam int DBW = $clog2(DEBOUNCE_MS + 1);
  localparam int TW  = $clog2(TIMEOUT_MS + 1);
  localparam int BW  = $clog2(BLINK_MS + 1);
  localparam logic [DBW-1:0] DB_RELOAD = DBW'(DEBOUNCE_MS - 1);
  localparam logic [TW-1:0]  T_RELOAD  = TW'(TIMEOUT_MS - 1);
  localparam logic [BW-1:0]  B_RELOAD  = BW'(BLINK_MS - 1);

  logic [2:0] btn_raw, sync1_q, sync2_q, press;
  logic       p_mode, p_inc, p_dec, any_press, step, editing, editing_d, timed_out;
  logic [2:0] state_q, state_d;
  logic [4:0] hr_q, hr_d, cur_hr;
  logic [5:0] min_q, min_d, sec_q, sec_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [BW-1:0] blink_cnt_q;
  logic       blink_q, load_en_q, load_d, set_active_q;
  logic [26:0] load_time_q, load_time_d;
  logic [1:0] field_sel_q, fsel_d;

  assign btn_raw = {btn_dec, btn_inc, btn_mode};

  always_ff @(posedge kh_clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // The press pulse coincides with the sample that accepts the new level, so the FSM acts on it at once.
  for (genvar b = 0; b < 3; b++) begin : g_db
    logic           lvl_q;
    logic [DBW-1:0] cnt_q;
    always_ff @(posedge kh_clk or posedge reset) begin
      if (reset) begin
        lvl_q <= 1'b0;
        cnt_q <= '0;
      end else if (sync2_q[b] == lvl_q) begin
        cnt_q <= DB_RELOAD;
      end else if (cnt_q == '0) begin
        lvl_q <= sync2_q[b];
        cnt_q <= DB_RELOAD;
      end else begin
        cnt_q <= cnt_q - DBW'(1);
      end
    end
    assign press[b] = sync2_q[b] & ~lvl_q & (cnt_q == '0);
  end

  assign p_mode    = press[0];
  assign p_inc     = press[1];
  assign p_dec     = press[2];
  assign any_press = |press;
  assign step      = p_inc ^ p_dec;
  assign cur_hr    = cur_time[26:22];
  assign editing   = (state_q == S_EDIT_HR) || (state_q == S_EDIT_MIN) || (state_q == S_EDIT_SEC);
  assign timed_out = !any_press && (idle_q == '0);

  function automatic logic [5:0] step_60(input logic [5:0] v, input logic up);
    if (up) return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

`ifdef CLOCK_SET_DST_EN
  logic dst_s1_q, dst_s2_q, dst_s3_q, pend_q, pend_up_q, pend_d, pend_up_d;
  logic dst_edge, dst_fire, fire_up;
  logic [4:0] dst_hr;

  assign dst_edge = dst_s2_q ^ dst_s3_q;
  assign dst_fire = (state_q == S_RUN) && (dst_edge || pend_q);
  assign fire_up  = dst_edge ? dst_s2_q : pend_up_q;
  assign dst_hr   = fire_up ? ((cur_hr >= 5'd23) ? 5'd0 : cur_hr + 5'd1)
                            : ((cur_hr == 5'd0) ? 5'd23 : cur_hr - 5'd1);

  // Opposite edges while pending cancel out; a committed edit supersedes any pending shift.
  always_comb begin
    pend_d    = pend_q;
    pend_up_d = pend_up_q;
    if (state_q == S_RUN) begin
      pend_d = 1'b0;
    end else if (dst_edge) begin
      if (pend_q && (pend_up_q != dst_s2_q)) begin
        pend_d = 1'b0;
      end else begin
        pend_d    = 1'b1;
        pend_up_d = dst_s2_q;
      end
    end
    if (state_d == S_COMMIT) pend_d = 1'b0;
  end

  always_ff @(posedge kh_clk or posedge reset) begin
    if (reset) begin
      dst_s1_q  <= 1'b0;
      dst_s2_q  <= 1'b0;
      dst_s3_q  <= 1'b0;
      pend_q    <= 1'b0;
      pend_up_q <= 1'b0;
    end else begin
      dst_s1_q  <= spring_szn;
      dst_s2_q  <= dst_s1_q;
      dst_s3_q  <= dst_s2_q;
      pend_q    <= pend_d;
      pend_up_q <= pend_up_d;
    end
  end
`else
  logic unused_ms;
  assign unused_ms = ^cur_time[9:0];
`endif

  always_comb begin
    state_d     = state_q;
    hr_d        = hr_q;
    min_d       = min_q;
    sec_d       = sec_q;
    load_d      = 1'b0;
    load_time_d = load_time_q;
    idle_d      = idle_q;
    if (any_press) idle_d = T_RELOAD;
    else if (editing && (idle_q != '0)) idle_d = idle_q - TW'(1);
    case (state_q)
      S_RUN: begin
`ifdef CLOCK_SET_DST_EN
        if (dst_fire) begin
          load_d      = 1'b1;
          load_time_d = {dst_hr, cur_time[21:0]};
        end else
`endif
        if (p_mode) begin
          hr_d    = (cur_hr > 5'd23) ? 5'd0 : cur_hr;
          min_d   = (cur_time[21:16] > 6'd59) ? 6'd0 : cur_time[21:16];
          sec_d   = (cur_time[15:10] > 6'd59) ? 6'd0 : cur_time[15:10];
          state_d = S_EDIT_HR;
        end
      end
      S_EDIT_HR: begin
        if (step) hr_d = p_inc ? ((hr_q >= 5'd23) ? 5'd0 : hr_q + 5'd1)
                               : ((hr_q == 5'd0) ? 5'd23 : hr_q - 5'd1);
        if (p_mode) state_d = S_EDIT_MIN;
        else if (timed_out) state_d = S_RUN;
      end
      S_EDIT_MIN: begin
        if (step) min_d = step_60(min_q, p_inc);
        if (p_mode) state_d = S_EDIT_SEC;
        else if (timed_out) state_d = S_RUN;
      end
      S_EDIT_SEC: begin
        if (step) sec_d = step_60(sec_q, p_inc);
        if (p_mode) state_d = S_COMMIT;
        else if (timed_out) state_d = S_RUN;
      end
      S_COMMIT: state_d = S_RUN;
      default:  state_d = S_RUN;
    endcase
    if (state_d == S_COMMIT) begin
      load_d      = 1'b1;
      load_time_d = {hr_d, min_d, sec_d, 10'd0};
    end
  end

  always_comb begin
    case (state_d)
      S_EDIT_HR:  fsel_d = 2'd1;
      S_EDIT_MIN: fsel_d = 2'd2;
      S_EDIT_SEC: fsel_d = 2'd3;
      default:    fsel_d = 2'd0;
    endcase
  end
  assign editing_d = (fsel_d != 2'd0);

  always_ff @(posedge kh_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_RUN;
      hr_q         <= '0;
      min_q        <= '0;
      sec_q        <= '0;
      idle_q       <= '0;
      blink_cnt_q  <= '0;
      blink_q      <= 1'b0;
      load_en_q    <= 1'b0;
      load_time_q  <= '0;
      set_active_q <= 1'b0;
      field_sel_q  <= '0;
    end else begin
      state_q      <= state_d;
      hr_q         <= hr_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      idle_q       <= idle_d;
      load_en_q    <= load_d;
      load_time_q  <= load_time_d;
      set_active_q <= editing_d;
      field_sel_q  <= fsel_d;
      if (!editing_d) begin
        blink_q     <= 1'b0;
        blink_cnt_q <= '0;
      end else if (state_d != state_q) begin
        blink_q     <= 1'b1;
        blink_cnt_q <= B_RELOAD;
      end else if (blink_cnt_q == '0) begin
        blink_q     <= ~blink_q;
        blink_cnt_q <= B_RELOAD;
      end else begin
        blink_cnt_q <= blink_cnt_q - BW'(1);
      end
    end
  end

  assign load_en    = load_en_q;
  assign load_time  = load_time_q;
  assign set_active = set_active_q;
  assign field_sel  = field_sel_q;
  assign blink      = blink_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios plus randomized edits checked
// against a modulo-arithmetic time model; DST scenarios are built when CLOCK_SET_DST_EN is defined.
`timescale 1ns/1ps
module tb_clock_set_ctrl;
  localparam int DB = 2, TO = 50, BL = 4, HOLD = 6;

  logic        kh_clk = 1'b0, reset = 1'b1;
  logic        btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [26:0] cur_time = '0;
`ifdef CLOCK_SET_DST_EN
  logic        spring_szn = 1'b0;
`endif
  logic        load_en, set_active, blink;
  logic [26:0] load_time;
  logic [1:0]  field_sel;

  int          n_checks = 0, n_errors = 0, load_cnt = 0;
  logic [26:0] last_load = '0;

  clock_set_ctrl #(.DEBOUNCE_MS(DB), .TIMEOUT_MS(TO), .BLINK_MS(BL)) dut (
    .kh_clk(kh_clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
`ifdef CLOCK_SET_DST_EN
    .spring_szn(spring_szn),
`endif
    .cur_time(cur_time), .load_en(load_en), .load_time(load_time),
    .set_active(set_active), .field_sel(field_sel), .blink(blink));

  always #5 kh_clk = ~kh_clk;

  always @(posedge kh_clk) begin
    #2;
    if (load_en) begin
      load_cnt++;
      last_load = load_time;
    end
  end

  function automatic logic [26:0] mk_time(input int h, input int m, input int s, input int ms);
    return {5'(h), 6'(m), 6'(s), 10'(ms)};
  endfunction

  // Expected committed value: clamp invalid captured fields to 0, then apply net steps modulo field range.
  function automatic logic [26:0] expect_commit(input logic [26:0] cap, input int dh, input int dm, input int ds);
    int h = int'(cap[26:22]);
    int m = int'(cap[21:16]);
    int s = int'(cap[15:10]);
    if (h > 23) h = 0;
    if (m > 59) m = 0;
    if (s > 59) s = 0;
    h = ((h + dh) % 24 + 24) % 24;
    m = ((m + dm) % 60 + 60) % 60;
    s = ((s + ds) % 60 + 60) % 60;
    return mk_time(h, m, s, 0);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge kh_clk);
  endtask

  task automatic press(input logic m, input logic i, input logic d);
    btn_mode = m; btn_inc = i; btn_dec = d;
    tick(HOLD);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    tick(HOLD);
  endtask

  task automatic run_edit(input int dh, input int dm, input int ds);
    int d[3];
    d[0] = dh; d[1] = dm; d[2] = ds;
    press(1, 0, 0);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < ((d[f] < 0) ? -d[f] : d[f]); k++) press(0, d[f] > 0, d[f] < 0);
      press(1, 0, 0);
    end
  endtask

  task automatic test_reset;
    tick(2);
    n_checks++; if (load_en !== 1'b0) begin n_errors++; $display("FAIL reset_load_en got=%b exp=0", load_en); end
    n_checks++; if (load_time !== 27'd0) begin n_errors++; $display("FAIL reset_load_time got=%h exp=0", load_time); end
    n_checks++; if (set_active !== 1'b0) begin n_errors++; $display("FAIL reset_set_active got=%b exp=0", set_active); end
    n_checks++; if (field_sel !== 2'd0) begin n_errors++; $display("FAIL reset_field_sel got=%0d exp=0", field_sel); end
    n_checks++; if (blink !== 1'b0) begin n_errors++; $display("FAIL reset_blink got=%b exp=0", blink); end
    reset = 1'b0;
    tick(3);
  endtask

  task automatic test_mid_edit_reset;
    int base;
    cur_time = mk_time(12, 34, 56, 7);
    run_edit(0, 0, 0);
    tick(2);
    base = load_cnt;
    press(1, 0, 0); press(1, 0, 0);
    n_checks++; if (field_sel !== 2'd2) begin n_errors++; $display("FAIL midreset_in_min got=%0d exp=2", field_sel); end
    reset = 1'b1;
    tick(1);
    n_checks++; if ({load_en, load_time, set_active, field_sel, blink} !== 32'd0)
      begin n_errors++; $display("FAIL midreset_outputs got=%b_%h_%b_%0d_%b exp=all0", load_en, load_time, set_active, field_sel, blink); end
    reset = 1'b0;
    tick(10);
    n_checks++; if (load_cnt !== base) begin n_errors++; $display("FAIL midreset_no_load got=%0d exp=%0d", load_cnt, base); end
    n_checks++; if (field_sel !== 2'd0) begin n_errors++; $display("FAIL midreset_run got=%0d exp=0", field_sel); end
  endtask

  task automatic test_wrap;
    int base = load_cnt;
    logic [26:0] exp;
    cur_time = mk_time(23, 59, 58, int'($urandom_range(0, 999)));
    exp = expect_commit(cur_time, 1, 1, -1);
    run_edit(1, 1, -1);
    tick(2);
    n_checks++; if (load_cnt !== base + 1) begin n_errors++; $display("FAIL wrap_load_count got=%0d exp=%0d", load_cnt - base, 1); end
    n_checks++; if (last_load !== exp) begin n_errors++; $display("FAIL wrap_load_time got=%h exp=%h", last_load, exp); end
    n_checks++; if (set_active !== 1'b0) begin n_errors++; $display("FAIL wrap_back_to_run got=%b exp=0", set_active); end
  endtask

  task automatic test_debounce;
    int base = load_cnt;
    logic [26:0] cap, exp;
    cap = mk_time(int'($urandom_range(0, 22)), 5, 6, 0);
    cur_time = cap;
    exp = expect_commit(cap, 1, 0, 0);
    btn_mode = 1'b1; tick(1); btn_mode = 1'b0; tick(10);
    n_checks++; if (field_sel !== 2'd0) begin n_errors++; $display("FAIL glitch_mode got=%0d exp=0", field_sel); end
    btn_mode = 1'b1;
    tick(3);
    n_checks++; if (field_sel !== 2'd0) begin n_errors++; $display("FAIL latency_early got=%0d exp=0", field_sel); end
    tick(1);
    n_checks++; if (field_sel !== 2'd1) begin n_errors++; $display("FAIL latency_exact got=%0d exp=1", field_sel); end
    btn_mode = 1'b0; tick(HOLD);
    btn_inc = 1'b1; tick(1); btn_inc = 1'b0; tick(10);
    press(0, 1, 0);
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    tick(2);
    n_checks++; if (load_cnt !== base + 1) begin n_errors++; $display("FAIL debounce_load_count got=%0d exp=1", load_cnt - base); end
    n_checks++; if (last_load !== exp) begin n_errors++; $display("FAIL debounce_hr_inc got=%h exp=%h", last_load, exp); end
  endtask

  task automatic test_simul_timeout;
    int base = load_cnt;
    logic [26:0] cap, exp;
    cap = mk_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)), 0);
    cur_time = cap;
    exp = expect_commit(cap, 0, 0, 0);
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    n_checks++; if (field_sel !== 2'd3) begin n_errors++; $display("FAIL simul_in_sec got=%0d exp=3", field_sel); end
    press(0, 1, 1);
    press(1, 0, 0);
    tick(2);
    n_checks++; if (last_load !== exp) begin n_errors++; $display("FAIL simul_sec_unchanged got=%h exp=%h", last_load, exp); end
    base = load_cnt;
    press(1, 0, 0);
    tick(TO - 8 - 4);
    n_checks++; if (set_active !== 1'b1) begin n_errors++; $display("FAIL timeout_early got=%b exp=1", set_active); end
    tick(8);
    n_checks++; if (set_active !== 1'b0 || field_sel !== 2'd0)
      begin n_errors++; $display("FAIL timeout_to_run got=%b/%0d exp=0/0", set_active, field_sel); end
    n_checks++; if (load_cnt !== base) begin n_errors++; $display("FAIL timeout_no_load got=%0d exp=%0d", load_cnt, base); end
  endtask

  task automatic test_clamp;
    logic [26:0] cap, exp;
    cap = mk_time(31, 60 + int'($urandom_range(0, 3)), 60 + int'($urandom_range(0, 3)), int'($urandom_range(0, 999)));
    cur_time = cap;
    exp = expect_commit(cap, 0, 0, 0);
    run_edit(0, 0, 0); tick(2);
    n_checks++; if (last_load !== exp) begin n_errors++; $display("FAIL clamp_zero got=%h exp=%h", last_load, exp); end
    exp = expect_commit(cap, -1, 0, 0);
    run_edit(-1, 0, 0); tick(2);
    n_checks++; if (last_load !== exp) begin n_errors++; $display("FAIL clamp_dec got=%h exp=%h", last_load, exp); end
  endtask

  task automatic test_blink;
    logic want;
    btn_mode = 1'b1; tick(4);
    n_checks++; if (field_sel !== 2'd1) begin n_errors++; $display("FAIL blink_entry got=%0d exp=1", field_sel); end
    for (int k = 0; k < 3 * BL; k++) begin
      want = ((k / BL) % 2) == 0;
      n_checks++; if (blink !== want) begin n_errors++; $display("FAIL blink_hr k=%0d got=%b exp=%b", k, blink, want); end
      if (k == 1) btn_mode = 1'b0;
      tick(1);
    end
    btn_mode = 1'b1; tick(4);
    for (int k = 0; k <= BL; k++) begin
      want = (k < BL);
      n_checks++; if (blink !== want) begin n_errors++; $display("FAIL blink_min k=%0d got=%b exp=%b", k, blink, want); end
      tick(1);
    end
    btn_mode = 1'b0; tick(HOLD);
    press(1, 0, 0); press(1, 0, 0);
    n_checks++; if (blink !== 1'b0) begin n_errors++; $display("FAIL blink_run got=%b exp=0", blink); end
  endtask

  task automatic test_mode_combo;
    logic [26:0] cap, exp;
    cap = mk_time(int'($urandom_range(0, 23)), 10, 20, 0);
    cur_time = cap;
    exp = expect_commit(cap, 1, 0, 0);
    press(1, 0, 0);
    press(1, 1, 0);
    n_checks++; if (field_sel !== 2'd2) begin n_errors++; $display("FAIL combo_advance got=%0d exp=2", field_sel); end
    press(1, 0, 0); press(1, 0, 0); tick(2);
    n_checks++; if (last_load !== exp) begin n_errors++; $display("FAIL combo_value got=%h exp=%h", last_load, exp); end
  endtask

  task automatic test_back_to_back;
    int base, dh, dm, ds;
    logic [26:0] cap, exp;
    for (int it = 0; it < 10; it++) begin
      cap = mk_time(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), int'($urandom_range(0, 1023)));
      cur_time = cap;
      base = load_cnt;
      press(0, $urandom_range(0, 1) == 1, 1'b0);
      n_checks++; if (field_sel !== 2'd0 || load_cnt !== base)
        begin n_errors++; $display("FAIL rand_run_ignore it=%0d got=%0d/%0d exp=0/%0d", it, field_sel, load_cnt, base); end
      dh = int'($urandom_range(0, 6)) - 3;
      dm = int'($urandom_range(0, 6)) - 3;
      ds = int'($urandom_range(0, 6)) - 3;
      exp = expect_commit(cap, dh, dm, ds);
      run_edit(dh, dm, ds);
      tick(2);
      n_checks++; if (load_cnt !== base + 1 || last_load !== exp)
        begin n_errors++; $display("FAIL rand_commit it=%0d got=%h(n=%0d) exp=%h(n=1)", it, last_load, load_cnt - base, exp); end
    end
  endtask

`ifdef CLOCK_SET_DST_EN
  task automatic test_dst;
    int base;
    logic [26:0] exp;
    cur_time = mk_time(23, 17, 42, 345);
    exp = mk_time((23 + 1) % 24, 17, 42, 345);
    base = load_cnt;
    spring_szn = 1'b1;
    for (int k = 0; k < 10 && load_cnt == base; k++) tick(1);
    tick(2);
    n_checks++; if (load_cnt !== base + 1 || last_load !== exp)
      begin n_errors++; $display("FAIL dst_rise got=%h(n=%0d) exp=%h(n=1)", last_load, load_cnt - base, exp); end
    cur_time = mk_time(0, 3, 4, 5);
    exp = mk_time(23, 3, 4, 5);
    base = load_cnt;
    spring_szn = 1'b0;
    for (int k = 0; k < 10 && load_cnt == base; k++) tick(1);
    tick(2);
    n_checks++; if (load_cnt !== base + 1 || last_load !== exp)
      begin n_errors++; $display("FAIL dst_fall got=%h(n=%0d) exp=%h(n=1)", last_load, load_cnt - base, exp); end
    cur_time = mk_time(9, 8, 7, 6);
    exp = mk_time(10, 8, 7, 6);
    base = load_cnt;
    press(1, 0, 0);
    spring_szn = 1'b1;
    tick(6);
    n_checks++; if (load_cnt !== base) begin n_errors++; $display("FAIL dst_held_in_edit got=%0d exp=%0d", load_cnt, base); end
    for (int k = 0; k < TO + 20 && load_cnt == base; k++) tick(1);
    tick(2);
    n_checks++; if (load_cnt !== base + 1 || last_load !== exp || set_active !== 1'b0)
      begin n_errors++; $display("FAIL dst_pending got=%h(n=%0d) exp=%h(n=1)", last_load, load_cnt - base, exp); end
    exp = expect_commit(cur_time, 0, 0, 0);
    base = load_cnt;
    press(1, 0, 0);
    spring_szn = 1'b0;
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    tick(10);
    n_checks++; if (load_cnt !== base + 1 || last_load !== exp)
      begin n_errors++; $display("FAIL dst_cancel got=%h(n=%0d) exp=%h(n=1)", last_load, load_cnt - base, exp); end
  endtask
`endif

  initial begin
    test_reset();
    test_mid_edit_reset();
    test_wrap();
    test_debounce();
    test_simul_timeout();
    test_clamp();
    test_blink();
    test_mode_combo();
    test_back_to_back();
`ifdef CLOCK_SET_DST_EN
    test_dst();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
